// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (iram / dram) to one shared memory port arbiter.
//
// Purpose
//   Selects one of two request ports per cycle and muxes it onto the shared
//   memory request bus. Conflicts alternate between the ports. A request that
//   stalls on mem_ready keeps the grant until it is accepted. The ID of every
//   accepted read is tracked in order, so each mem_rvalid goes back to the
//   port that issued that read.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   iram_req/write/wstrb/addr/wdata instruction-side request
//   iram_ready/rvalid/rdata         instruction-side handshake and response
//   dram_req/write/wstrb/addr/wdata data-side request
//   dram_ready/rvalid/rdata         data-side handshake and response
//   mem_req/write/wstrb/addr/wdata  shared memory request
//   mem_ready/rvalid/rdata          shared memory handshake and response
//   outst_cnt                       reads currently in flight
//   err_rvalid                      sticky flag: mem_rvalid seen with nothing in flight
module mem_arbiter #(
   parameter int XLEN      = 32,
   parameter int MAX_OUTST = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       iram_req,
   input  logic                       iram_write,
   input  logic [XLEN/8-1:0]          iram_wstrb,
   input  logic [XLEN-1:0]            iram_addr,
   input  logic [XLEN-1:0]            iram_wdata,
   output logic                       iram_ready,
   output logic                       iram_rvalid,
   output logic [XLEN-1:0]            iram_rdata,
   input  logic                       dram_req,
   input  logic                       dram_write,
   input  logic [XLEN/8-1:0]          dram_wstrb,
   input  logic [XLEN-1:0]            dram_addr,
   input  logic [XLEN-1:0]            dram_wdata,
   output logic                       dram_ready,
   output logic                       dram_rvalid,
   output logic [XLEN-1:0]            dram_rdata,
   output logic                       mem_req,
   output logic                       mem_write,
   output logic [XLEN/8-1:0]          mem_wstrb,
   output logic [XLEN-1:0]            mem_addr,
   output logic [XLEN-1:0]            mem_wdata,
   input  logic                       mem_ready,
   input  logic                       mem_rvalid,
   input  logic [XLEN-1:0]            mem_rdata,
   output logic [$clog2(MAX_OUTST):0] outst_cnt,
   output logic                       err_rvalid
);

   localparam int PW = $clog2(MAX_OUTST);
   localparam int CW = PW + 1;

   typedef enum logic {
      SRC_IRAM = 1'b0,
      SRC_DRAM = 1'b1
   } src_e;

   // Control state
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          lock_q, lock_d;
   src_e          lock_src_q, lock_src_d;
   src_e          last_q, last_d;
   logic          err_q, err_d;

   // Source-ID storage. It is not reset because cnt_q/pointers decide validity.
   src_e          fifo_q [MAX_OUTST];

   logic          gnt_vld;
   src_e          gnt_src;
   logic          full, empty, issue, accept, push, pop;
   src_e          head;

   // Grant selection. A locked grant ignores the other port completely.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_src = SRC_IRAM;
      if (lock_q) begin
         gnt_src = lock_src_q;
         gnt_vld = (lock_src_q == SRC_DRAM) ? dram_req : iram_req;
      end else if (iram_req && dram_req) begin
         gnt_vld = 1'b1;
         gnt_src = (last_q == SRC_IRAM) ? SRC_DRAM : SRC_IRAM;
      end else if (iram_req) begin
         gnt_vld = 1'b1;
         gnt_src = SRC_IRAM;
      end else if (dram_req) begin
         gnt_vld = 1'b1;
         gnt_src = SRC_DRAM;
      end
   end

   // full uses the registered count, so a same-cycle pop cannot free a slot.
   assign full   = (cnt_q == CW'(MAX_OUTST));
   assign empty  = (cnt_q == '0);
   assign issue  = gnt_vld & ~full & ~rst;
   assign accept = issue & mem_ready;
   assign push   = accept & ~mem_write;
   assign pop    = mem_rvalid & ~empty & ~rst;
   assign head   = fifo_q[rptr_q];

   assign mem_req   = issue;
   assign mem_write = (gnt_src == SRC_DRAM) ? dram_write : iram_write;
   assign mem_wstrb = (gnt_src == SRC_DRAM) ? dram_wstrb : iram_wstrb;
   assign mem_addr  = (gnt_src == SRC_DRAM) ? dram_addr  : iram_addr;
   assign mem_wdata = (gnt_src == SRC_DRAM) ? dram_wdata : iram_wdata;

   assign iram_ready  = issue & mem_ready & (gnt_src == SRC_IRAM);
   assign dram_ready  = issue & mem_ready & (gnt_src == SRC_DRAM);
   assign iram_rvalid = pop & (head == SRC_IRAM);
   assign dram_rvalid = pop & (head == SRC_DRAM);
   assign iram_rdata  = mem_rdata;
   assign dram_rdata  = mem_rdata;

   assign outst_cnt  = cnt_q;
   assign err_rvalid = err_q;

   always_comb begin
      cnt_d      = cnt_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      lock_d     = lock_q;
      lock_src_d = lock_src_q;
      last_d     = last_q;
      err_d      = err_q | (mem_rvalid & empty);

      if (push)         wptr_d = wptr_q + PW'(1);
      if (pop)          rptr_d = rptr_q + PW'(1);
      if (push && !pop) cnt_d  = cnt_q + CW'(1);
      if (pop && !push) cnt_d  = cnt_q - CW'(1);

      // Lock is taken on a stalled request, released on acceptance or
      // when the locked requester withdraws.
      if (accept) begin
         lock_d = 1'b0;
      end else if (issue && !mem_ready) begin
         lock_d     = 1'b1;
         lock_src_d = gnt_src;
      end else if (lock_q && !gnt_vld) begin
         lock_d = 1'b0;
      end

      if (accept && iram_req && dram_req) last_d = gnt_src;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         lock_q     <= 1'b0;
         lock_src_q <= SRC_IRAM;
         last_q     <= SRC_IRAM;
         err_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         lock_q     <= lock_d;
         lock_src_q <= lock_src_d;
         last_q     <= last_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q] <= gnt_src;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (XLEN=32, MAX_OUTST=4).
// Inputs change 1 time unit after the rising edge. Outputs are sampled
// 1 time unit later, well before the next edge.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        iram_req, iram_write;
   logic [3:0]  iram_wstrb;
   logic [31:0] iram_addr, iram_wdata;
   logic        iram_ready, iram_rvalid;
   logic [31:0] iram_rdata;
   logic        dram_req, dram_write;
   logic [3:0]  dram_wstrb;
   logic [31:0] dram_addr, dram_wdata;
   logic        dram_ready, dram_rvalid;
   logic [31:0] dram_rdata;
   logic        mem_req, mem_write;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready, mem_rvalid;
   logic [31:0] mem_rdata;
   logic [2:0]  outst_cnt;
   logic        err_rvalid;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.XLEN(32), .MAX_OUTST(4)) dut (
      .clk(clk), .rst(rst),
      .iram_req(iram_req), .iram_write(iram_write), .iram_wstrb(iram_wstrb),
      .iram_addr(iram_addr), .iram_wdata(iram_wdata),
      .iram_ready(iram_ready), .iram_rvalid(iram_rvalid), .iram_rdata(iram_rdata),
      .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
      .dram_addr(dram_addr), .dram_wdata(dram_wdata),
      .dram_ready(dram_ready), .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
      .mem_req(mem_req), .mem_write(mem_write), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .outst_cnt(outst_cnt), .err_rvalid(err_rvalid)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; callers then drive inputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      iram_req = 1'b1; iram_write = 1'b0; iram_wstrb = 4'h0; iram_addr = 32'h0; iram_wdata = 32'h0;
      dram_req = 1'b1; dram_write = 1'b0; dram_wstrb = 4'h0; dram_addr = 32'h0; dram_wdata = 32'h0;
      mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;

      // Reset: requests present, yet nothing may be granted or issued.
      tick(); settle();
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_iram_ready", iram_ready, 1'b0);
      chk1("rst_dram_ready", dram_ready, 1'b0);
      chk32("rst_outst_cnt", 32'(outst_cnt), 32'd0);
      chk1("rst_err", err_rvalid, 1'b0);

      // Both read in cycle 0: the first conflict goes to dram, then iram follows.
      tick();
      rst = 1'b0; iram_addr = 32'h100; dram_addr = 32'h200;
      settle();
      chk1("c0_mem_req", mem_req, 1'b1);
      chk32("c0_mem_addr", mem_addr, 32'h200);
      chk1("c0_dram_ready", dram_ready, 1'b1);
      chk1("c0_iram_ready", iram_ready, 1'b0);
      tick();
      dram_req = 1'b0;
      settle();
      chk32("c1_mem_addr", mem_addr, 32'h100);
      chk1("c1_iram_ready", iram_ready, 1'b1);
      chk32("c1_outst", 32'(outst_cnt), 32'd1);
      tick();
      iram_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA;
      settle();
      chk32("c2_outst", 32'(outst_cnt), 32'd2);
      chk1("c2_mem_req_idle", mem_req, 1'b0);
      chk1("rsp_a_dram_rvalid", dram_rvalid, 1'b1);
      chk1("rsp_a_iram_rvalid", iram_rvalid, 1'b0);
      chk32("rsp_a_dram_rdata", dram_rdata, 32'hA);
      tick();
      mem_rdata = 32'hB;
      settle();
      chk1("rsp_b_iram_rvalid", iram_rvalid, 1'b1);
      chk1("rsp_b_dram_rvalid", dram_rvalid, 1'b0);
      chk32("rsp_b_iram_rdata", iram_rdata, 32'hB);
      chk32("rsp_b_outst", 32'(outst_cnt), 32'd1);
      tick();
      mem_rvalid = 1'b0;
      settle();
      chk32("drain_outst", 32'(outst_cnt), 32'd0);

      // dram write together with iram read: iram wins this conflict, and the
      // write creates no tracker entry.
      tick();
      iram_req = 1'b1; iram_addr = 32'h500;
      dram_req = 1'b1; dram_write = 1'b1; dram_wstrb = 4'b0011; dram_addr = 32'h600; dram_wdata = 32'hDEAD;
      settle();
      chk32("wr_c0_mem_addr", mem_addr, 32'h500);
      chk1("wr_c0_iram_ready", iram_ready, 1'b1);
      chk1("wr_c0_mem_write", mem_write, 1'b0);
      tick();
      iram_req = 1'b0;
      settle();
      chk32("wr_c1_mem_addr", mem_addr, 32'h600);
      chk1("wr_c1_mem_write", mem_write, 1'b1);
      chk32("wr_c1_mem_wstrb", 32'(mem_wstrb), 32'h3);
      chk32("wr_c1_mem_wdata", mem_wdata, 32'hDEAD);
      chk1("wr_c1_dram_ready", dram_ready, 1'b1);
      tick();
      dram_req = 1'b0; dram_write = 1'b0; dram_wstrb = 4'h0;
      settle();
      chk32("wr_outst_end", 32'(outst_cnt), 32'd1);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hC;
      settle();
      chk1("wr_rsp_iram_rvalid", iram_rvalid, 1'b1);
      tick();
      mem_rvalid = 1'b0;
      settle();
      chk32("wr_drain_outst", 32'(outst_cnt), 32'd0);

      // Lock: iram stalls 3 cycles, dram arrives in cycle 1 and would win the
      // conflict, but the grant is held on iram.
      tick();
      iram_req = 1'b1; iram_addr = 32'h300; mem_ready = 1'b0;
      settle();
      chk1("lk_c0_mem_req", mem_req, 1'b1);
      chk32("lk_c0_mem_addr", mem_addr, 32'h300);
      chk1("lk_c0_iram_ready", iram_ready, 1'b0);
      tick();
      dram_req = 1'b1; dram_addr = 32'h400;
      settle();
      chk32("lk_c1_mem_addr", mem_addr, 32'h300);
      chk1("lk_c1_dram_ready", dram_ready, 1'b0);
      tick();
      settle();
      chk32("lk_c2_mem_addr", mem_addr, 32'h300);
      tick();
      mem_ready = 1'b1;
      settle();
      chk32("lk_c3_mem_addr", mem_addr, 32'h300);
      chk1("lk_c3_iram_ready", iram_ready, 1'b1);
      chk1("lk_c3_dram_ready", dram_ready, 1'b0);
      tick();
      iram_req = 1'b0;
      settle();
      chk32("lk_c4_mem_addr", mem_addr, 32'h400);
      chk1("lk_c4_dram_ready", dram_ready, 1'b1);
      chk32("lk_c4_outst", 32'(outst_cnt), 32'd1);
      tick();
      dram_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11;
      settle();
      chk1("lk_rsp0_iram_rvalid", iram_rvalid, 1'b1);
      tick();
      mem_rdata = 32'h22;
      settle();
      chk1("lk_rsp1_dram_rvalid", dram_rvalid, 1'b1);
      chk1("lk_rsp1_iram_rvalid", iram_rvalid, 1'b0);

      // Unexpected response with an empty tracker.
      tick();
      mem_rdata = 32'h33;
      settle();
      chk32("unexp_outst", 32'(outst_cnt), 32'd0);
      chk1("unexp_iram_rvalid", iram_rvalid, 1'b0);
      chk1("unexp_dram_rvalid", dram_rvalid, 1'b0);
      chk1("unexp_err_before", err_rvalid, 1'b0);
      tick();
      mem_rvalid = 1'b0;
      settle();
      chk1("unexp_err_set", err_rvalid, 1'b1);
      tick();
      settle();
      chk1("unexp_err_sticky", err_rvalid, 1'b1);

      // Fill the tracker with 4 iram reads.
      tick();
      iram_req = 1'b1; iram_addr = 32'h700;
      settle();
      chk1("fill0_iram_ready", iram_ready, 1'b1);
      tick(); settle();
      tick(); settle();
      tick(); settle();
      chk32("fill3_outst", 32'(outst_cnt), 32'd3);
      tick();
      settle();
      chk32("full_outst", 32'(outst_cnt), 32'd4);
      chk1("full_mem_req", mem_req, 1'b0);
      chk1("full_iram_ready", iram_ready, 1'b0);
      chk1("full_dram_ready", dram_ready, 1'b0);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h44;
      settle();
      chk1("full_pop_mem_req", mem_req, 1'b0);
      chk1("full_pop_iram_ready", iram_ready, 1'b0);
      chk1("full_pop_iram_rvalid", iram_rvalid, 1'b1);
      tick();
      mem_rvalid = 1'b0;
      settle();
      chk32("after_pop_outst", 32'(outst_cnt), 32'd3);
      chk1("after_pop_mem_req", mem_req, 1'b1);
      chk1("after_pop_iram_ready", iram_ready, 1'b1);
      tick();
      iram_req = 1'b0;
      settle();
      chk32("refill_outst", 32'(outst_cnt), 32'd4);

      // Drop to 2 outstanding, then reset in the middle of the traffic.
      tick();
      mem_rvalid = 1'b1;
      settle();
      tick();
      settle();
      tick();
      mem_rvalid = 1'b0;
      settle();
      chk32("pre_rst_outst", 32'(outst_cnt), 32'd2);
      tick();
      rst = 1'b1; iram_req = 1'b1; dram_req = 1'b1;
      settle();
      chk1("mid_rst_mem_req", mem_req, 1'b0);
      chk1("mid_rst_iram_ready", iram_ready, 1'b0);
      chk1("mid_rst_dram_ready", dram_ready, 1'b0);
      tick();
      rst = 1'b0; iram_req = 1'b0; dram_req = 1'b0;
      settle();
      chk32("post_rst_outst", 32'(outst_cnt), 32'd0);
      chk1("post_rst_err", err_rvalid, 1'b0);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h55;
      settle();
      chk1("late_iram_rvalid", iram_rvalid, 1'b0);
      chk1("late_dram_rvalid", dram_rvalid, 1'b0);
      tick();
      mem_rvalid = 1'b0;
      settle();
      chk1("late_err", err_rvalid, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
